blend_feed: RTL and testbench

//  Upstream feeder for the alpha mixer. Per scanline, walks the background and sprite line

---
 rtl/blend_feed_if.sv | 47 ++++
 rtl/blend_feed.sv | 165 ++++++++++++++++
 tb/tb_blend_feed.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blend_feed_if.sv
`default_nettype none
// ============================================================================
// Module   : blend_feed_if
// Purpose  : Bundles the line-buffer, palette-write, video-timing and
//            mixer-side signals of blend_feed.
// Modports : master - the feeder (drives addresses, colours, delayed timing)
//            slave  - the surroundings (line buffers, timing gen, CPU, mixer)
// Revision : 1.0 - initial release
// ============================================================================
interface blend_feed_if #(
  parameter int LB_AW = 9
);
  logic             pix_en;
  logic             line_start;
  logic [LB_AW-1:0] bg_addr;
  logic [7:0]       bg_data;
  logic [LB_AW-1:0] spr_addr;
  logic [7:0]       spr_data;
  logic             pal_wr;
  logic [4:0]       pal_wr_idx;
  logic [11:0]      pal_wr_data;
  logic             hsync_in, vsync_in, de_in;
  logic             hsync_out, vsync_out, de_out;
  logic [3:0]       r0, g0, b0;
  logic [3:0]       r1, g1, b1;
  logic [3:0]       alpha;
  logic             valid;

  modport master (
    input  pix_en, line_start, bg_data, spr_data,
    input  pal_wr, pal_wr_idx, pal_wr_data,
    input  hsync_in, vsync_in, de_in,
    output bg_addr, spr_addr,
    output hsync_out, vsync_out, de_out,
    output r0, g0, b0, r1, g1, b1, alpha, valid
  );

  modport slave (
    output pix_en, line_start, bg_data, spr_data,
    output pal_wr, pal_wr_idx, pal_wr_data,
    output hsync_in, vsync_in, de_in,
    input  bg_addr, spr_addr,
    input  hsync_out, vsync_out, de_out,
    input  r0, g0, b0, r1, g1, b1, alpha, valid
  );
endinterface
`default_nettype wire

// File: rtl/blend_feed.sv
`default_nettype none
// ============================================================================
// Module   : blend_feed
// Purpose  : Per-scanline feeder for the alpha mixer. Walks the background
//            and sprite line buffers, maps 4-bit indices through two 16-entry
//            12-bit palettes and presents both colours plus alpha, with the
//            video timing delayed by the same three pix_en stages.
// Ports    : CLK  - system clock
//            RSTb - asynchronous active-low reset
//            bus  - blend_feed_if.master (line buffers, palette write port,
//                   timing in/out, mixer colour outputs)
// Revision : 1.0 - initial release
// ============================================================================
module blend_feed #(
  parameter int LB_AW    = 9,
  parameter int H_ACTIVE = 320
) (
  input  wire logic    CLK,
  input  wire logic    RSTb,
  blend_feed_if.master bus
);

  localparam logic [LB_AW-1:0] c_LAST = LB_AW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [LB_AW-1:0] r_x;
  logic [LB_AW-1:0] r_addr;
  logic             r_s0_v;
  logic             r_drain;

  logic             r_s1_v;
  logic [3:0]       r_bg_idx;
  logic [7:0]       r_spr_pix;
  logic [11:0]      r_rgb0, r_rgb1;
  logic [3:0]       r_alpha;
  logic             r_valid;
  logic [2:0]       r_hs, r_vs, r_de;

  // Entries 0-15 background, 16-31 sprite.
  logic [11:0]      r_pal [32];

  // A line_start takes effect in the same clock it is seen: the FSM behaves
  // as if already in RUN at x=0, and everything in flight is discarded.
  state_t           w_state;
  logic [LB_AW-1:0] w_x;
  logic             w_s0_live, w_s1_live;
  logic [11:0]      w_bg_rgb, w_spr_rgb;
  logic             w_unused;

  assign w_state   = bus.line_start ? ST_RUN : r_state;
  assign w_x       = bus.line_start ? '0 : r_x;
  assign w_s0_live = r_s0_v & ~bus.line_start;
  assign w_s1_live = r_s1_v & ~bus.line_start;
  assign w_bg_rgb  = r_pal[{1'b0, r_bg_idx}];
  assign w_spr_rgb = r_pal[{1'b1, r_spr_pix[3:0]}];
  assign w_unused  = ^bus.bg_data[7:4];

  // Line walker: issues one address per pix_en, then two empty drain slots.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_addr  <= '0;
      r_s0_v  <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      if (bus.line_start) begin
        r_state <= ST_RUN;
        r_x     <= '0;
        r_s0_v  <= 1'b0;
        r_drain <= 1'b0;
      end
      if (bus.pix_en) begin
        case (w_state)
          ST_RUN: begin
            r_addr <= w_x;
            r_s0_v <= 1'b1;
            if (w_x == c_LAST) begin
              r_state <= ST_DRAIN;
              r_drain <= 1'b0;
            end else begin
              r_x <= w_x + 1'b1;
            end
          end
          ST_DRAIN: begin
            r_s0_v  <= 1'b0;
            r_drain <= 1'b1;
            if (r_drain) r_state <= ST_IDLE;
          end
          default: r_s0_v <= 1'b0;
        endcase
      end
    end
  end

  // S1 capture of line-buffer data, S2 palette lookup, and the timing delay.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_s1_v    <= 1'b0;
      r_bg_idx  <= '0;
      r_spr_pix <= '0;
      r_rgb0    <= '0;
      r_rgb1    <= '0;
      r_alpha   <= '0;
      r_valid   <= 1'b0;
      r_hs      <= '0;
      r_vs      <= '0;
      r_de      <= '0;
    end else begin
      // Without pix_en the S1 valid bit only holds, unless a line_start
      // discards it.
      r_s1_v <= bus.pix_en ? w_s0_live : w_s1_live;
      if (bus.pix_en) begin
        r_bg_idx  <= bus.bg_data[3:0];
        r_spr_pix <= bus.spr_data;
        r_hs      <= {r_hs[1:0], bus.hsync_in};
        r_vs      <= {r_vs[1:0], bus.vsync_in};
        r_de      <= {r_de[1:0], bus.de_in};
        if (w_s1_live) begin
          r_rgb0  <= w_bg_rgb;
          r_rgb1  <= w_spr_rgb;
          // Sprite index 0 is transparent whatever its alpha nibble says.
          r_alpha <= (r_spr_pix[3:0] == 4'd0) ? 4'd0 : r_spr_pix[7:4];
          r_valid <= 1'b1;
        end else begin
          r_rgb0  <= '0;
          r_rgb1  <= '0;
          r_alpha <= '0;
          r_valid <= 1'b0;
        end
      end
    end
  end

  // Palette writes ignore pix_en; a lookup on the same edge sees the old value.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < 32; i++) r_pal[i] <= '0;
    end else if (bus.pal_wr) begin
      r_pal[bus.pal_wr_idx] <= bus.pal_wr_data;
    end
  end

  assign bus.bg_addr   = r_addr;
  assign bus.spr_addr  = r_addr;
  assign bus.r0        = r_rgb0[11:8];
  assign bus.g0        = r_rgb0[7:4];
  assign bus.b0        = r_rgb0[3:0];
  assign bus.r1        = r_rgb1[11:8];
  assign bus.g1        = r_rgb1[7:4];
  assign bus.b1        = r_rgb1[3:0];
  assign bus.alpha     = r_alpha;
  assign bus.valid     = r_valid;
  assign bus.hsync_out = r_hs[2];
  assign bus.vsync_out = r_vs[2];
  assign bus.de_out    = r_de[2];

endmodule
`default_nettype wire

// File: tb/tb_blend_feed.sv
`default_nettype none
// ============================================================================
// Module   : tb_blend_feed
// Purpose  : Self-checking bench for blend_feed. A line-level reference
//            model (issue counter, per-enable history, palette array)
//            predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blend_feed;

  localparam int c_AW = 9;
  localparam int c_H  = 8;

  logic CLK  = 1'b0;
  logic RSTb = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  blend_feed_if #(.LB_AW(c_AW)) bus ();

  blend_feed #(.LB_AW(c_AW), .H_ACTIVE(c_H)) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  // Line buffers: synchronous RAMs whose read data for the address issued at
  // one rising edge is ready by the next one.
  logic [7:0] bgm  [512];
  logic [7:0] sprm [512];
  always @(negedge CLK) begin
    bus.bg_data  <= bgm[bus.bg_addr];
    bus.spr_data <= sprm[bus.spr_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit         iss;
    int         gen;
    logic [7:0] bgd, sprd;
    logic       hs, vs, de;
  } rec_t;

  rec_t        hist[$];
  int          gen, nx, rem;
  logic [11:0] pal [32];
  logic [11:0] e_rgb0, e_rgb1;
  logic [3:0]  e_alpha;
  logic        e_valid, e_hs, e_vs, e_de;
  logic [8:0]  e_addr;

  task automatic model_reset();
    hist.delete();
    gen = 0; nx = 0; rem = 0;
    for (int i = 0; i < 32; i++) pal[i] = '0;
    e_rgb0 = '0; e_rgb1 = '0; e_alpha = '0; e_valid = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_addr = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    rec_t old, cur;
    if (!RSTb) begin
      model_reset();
      return;
    end
    if (bus.line_start) begin
      gen++;
      nx  = 0;
      rem = c_H;
    end
    if (bus.pix_en) begin
      old = '{iss: 0, gen: 0, bgd: 0, sprd: 0, hs: 0, vs: 0, de: 0};
      if (hist.size() == 2) old = hist[0];
      e_hs = old.hs; e_vs = old.vs; e_de = old.de;
      if (old.iss && old.gen == gen) begin
        e_rgb0  = pal[{1'b0, old.bgd[3:0]}];
        e_rgb1  = pal[{1'b1, old.sprd[3:0]}];
        e_alpha = (old.sprd[3:0] == 0) ? 4'd0 : old.sprd[7:4];
        e_valid = 1;
      end else begin
        e_rgb0 = '0; e_rgb1 = '0; e_alpha = '0; e_valid = 0;
      end
      cur = '{iss: (rem > 0), gen: gen, bgd: 0, sprd: 0,
              hs: bus.hsync_in, vs: bus.vsync_in, de: bus.de_in};
      if (rem > 0) begin
        cur.bgd  = bgm[nx];
        cur.sprd = sprm[nx];
        e_addr   = 9'(nx);
        nx++;
        rem--;
      end
      hist.push_back(cur);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    if (bus.pal_wr) pal[bus.pal_wr_idx] = bus.pal_wr_data;
  endtask

  function automatic logic [49:0] obs();
    return {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1, bus.alpha,
            bus.valid, bus.hsync_out, bus.vsync_out, bus.de_out,
            bus.bg_addr, bus.spr_addr};
  endfunction

  function automatic logic [49:0] expv();
    return {e_rgb0, e_rgb1, e_alpha, e_valid, e_hs, e_vs, e_de, e_addr, e_addr};
  endfunction

  task automatic drive(input logic pe, input logic ls, input logic pw,
                       input logic [4:0] idx, input logic [11:0] d);
    bus.pix_en      = pe;
    bus.line_start  = ls;
    bus.pal_wr      = pw;
    bus.pal_wr_idx  = idx;
    bus.pal_wr_data = d;
  endtask

  task automatic set_sync(input logic hs, input logic vs, input logic de);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.de_in    = de;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 12'($urandom));
      set_sync(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      if (obs() !== 50'd0) begin
        bad++;
        $display("FAIL reset_hold c=%0d got=%h want=0", c, obs());
      end
      total++;
    end
    RSTb = 1'b1;
    drive(0, 0, 0, 0, 0);
    set_sync(0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1'(c), 0, 0, 0, 0);
      tick();
      if (obs() !== 50'd0) begin
        bad++;
        $display("FAIL reset_release c=%0d got=%h want=0", c, obs());
      end
      total++;
    end
  endtask

  task automatic test_basic();
    bgm[0] = 8'h03; sprm[0] = 8'hA5;
    bgm[1] = 8'h03; sprm[1] = 8'hF0;
    drive(0, 0, 1, 5'd3, 12'hF80);  tick();
    drive(0, 0, 1, 5'd21, 12'h0F0); tick();
    for (int c = 0; c < 14; c++) begin
      drive(1, (c == 0), 0, 0, 0);
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL basic_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
      if (c == 2) begin
        if ({bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1, bus.alpha, bus.valid}
            !== {12'hF80, 12'h0F0, 4'hA, 1'b1}) begin
          bad++;
          $display("FAIL basic_pixel0 got=%h %h%h%h a=%h v=%b want=F80 0F0 a=A v=1",
                   {bus.r0, bus.g0, bus.b0}, bus.r1, bus.g1, bus.b1, bus.alpha, bus.valid);
        end
        total++;
      end
      if (c == 3) begin
        if ({bus.alpha, bus.valid, bus.r1, bus.g1, bus.b1} !== {4'h0, 1'b1, 12'h000}) begin
          bad++;
          $display("FAIL basic_transparent got a=%h v=%b rgb1=%h%h%h want a=0 v=1 rgb1=000",
                   bus.alpha, bus.valid, bus.r1, bus.g1, bus.b1);
        end
        total++;
      end
    end
  endtask

  task automatic test_line();
    int nvalid = 0;
    for (int c = 0; c < 14; c++) begin
      if ($urandom_range(0, 9) < 3)
        drive(1, (c == 0), 1, 5'($urandom), 12'($urandom));
      else
        drive(1, (c == 0), 0, 0, 0);
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL line_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
      if (bus.valid === 1'b1) nvalid++;
    end
    if (nvalid != c_H) begin
      bad++;
      $display("FAIL line_count got=%0d want=%0d", nvalid, c_H);
    end
    total++;
  endtask

  task automatic test_sparse_sync();
    for (int c = 0; c < 48; c++) begin
      drive((c % 3 == 0), (c == 0), 0, 0, 0);
      set_sync(1'($urandom), 1'($urandom), (c >= 3 && c <= 5));
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL sparse_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
      if (c >= 8 && c <= 12) begin
        if (bus.de_out !== ((c >= 9 && c <= 11) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL sparse_de c=%0d got=%b want=%b", c, bus.de_out,
                   (c >= 9 && c <= 11));
        end
        total++;
      end
    end
    set_sync(0, 0, 0);
  endtask

  task automatic test_abort();
    // Restart after addresses 0..5 have been issued.
    for (int c = 0; c < 18; c++) begin
      drive(1, (c == 0 || c == 6), 0, 0, 0);
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL abort_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
    end
    // Asynchronous reset in the middle of a line.
    for (int c = 0; c < 5; c++) begin
      drive(1, (c == 0), 0, 0, 0);
      tick();
    end
    #2 RSTb = 1'b0;
    #1;
    if (obs() !== 50'd0) begin
      bad++;
      $display("FAIL abort_async_reset got=%h want=0", obs());
    end
    total++;
    model_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    RSTb = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(1, (c == 0), 0, 0, 0);
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL abort_after_reset c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
      if (bus.valid === 1'b1 &&
          {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} !== 24'd0) begin
        bad++;
        $display("FAIL abort_pal_cleared c=%0d got=%h want=0", c,
                 {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1});
      end
      total++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 9) == 0), 5'($urandom), 12'($urandom));
      set_sync(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      total++;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      bgm[i]  = 8'($urandom);
      sprm[i] = 8'($urandom);
    end
    model_reset();
    drive(0, 0, 0, 0, 0);
    set_sync(0, 0, 0);
    #1;
    test_reset();
    test_basic();
    test_line();
    test_sparse_sync();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
